// File: rtl/keypad_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : keypad_pkg                                                 |
// | Brief   : Shared types, constants and helpers for the keypad scanner |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } scan_state_t;

  // All rows released (active-low drive)
  localparam logic [3:0] ROW_IDLE = 4'b1111;

  // True when exactly one bit of a 4-bit vector is set
  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Row index to one-hot (active-high)
  function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : keypad_decoder                                             |
// | Brief   : Combinational one-hot row/column to hex key code mapping   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module keypad_decoder (
  input  logic [3:0] row_onehot,
  input  logic [3:0] col_onehot,
  output logic [3:0] key_code
);

  // Map physical key position to its printed legend; illegal combos give 0
  always_comb begin
    key_code = 4'h0;
    case ({row_onehot, col_onehot})
      8'b0001_0001: key_code = 4'h1;
      8'b0001_0010: key_code = 4'h2;
      8'b0001_0100: key_code = 4'h3;
      8'b0001_1000: key_code = 4'hC;
      8'b0010_0001: key_code = 4'h4;
      8'b0010_0010: key_code = 4'h5;
      8'b0010_0100: key_code = 4'h6;
      8'b0010_1000: key_code = 4'hD;
      8'b0100_0001: key_code = 4'h7;
      8'b0100_0010: key_code = 4'h8;
      8'b0100_0100: key_code = 4'h9;
      8'b0100_1000: key_code = 4'hE;
      8'b1000_0001: key_code = 4'hA;
      8'b1000_0010: key_code = 4'h0;
      8'b1000_0100: key_code = 4'hB;
      8'b1000_1000: key_code = 4'hF;
      default:      key_code = 4'h0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : keypad_scanner                                             |
// | Brief   : 4x4 matrix keypad row scanner with press/release debounce, |
// |           one key_valid pulse per accepted press                     |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module keypad_scanner #(
  parameter int SCAN_DIV        = 16,
  parameter int DEBOUNCE_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  import keypad_pkg::*;

  localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [3:0]       sync1_q, sync2_q;
  logic [3:0]       col_act;
  scan_state_t      state_q;
  logic [1:0]       row_idx_q;
  logic [3:0]       row_n_q;
  logic [CNT_W-1:0] dwell_q;
  logic [CNT_W-1:0] db_q;
  logic [3:0]       cap_row_q;
  logic [3:0]       cap_col_q;
  logic [3:0]       key_code_q;
  logic             key_valid_q;
  logic             key_held_q;
  logic [3:0]       dec_code;
  logic             cap_bit_set;

  // Columns are asynchronous to clk: two-flop synchronizer, idle-high reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= ROW_IDLE;
      sync2_q <= ROW_IDLE;
    end else begin
      sync1_q <= col_n;
      sync2_q <= sync1_q;
    end
  end

  assign col_act     = ~sync2_q;
  // Only the captured column matters once a key is held (first key wins)
  assign cap_bit_set = (col_act & cap_col_q) != 4'd0;

  keypad_decoder u_decoder (
    .row_onehot (cap_row_q),
    .col_onehot (cap_col_q),
    .key_code   (dec_code)
  );

  // Scan / debounce state machine with dwell and debounce counters and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= SCAN;
      row_idx_q   <= 2'd0;
      row_n_q     <= 4'b1110;
      dwell_q     <= '0;
      db_q        <= '0;
      cap_row_q   <= 4'd0;
      cap_col_q   <= 4'd0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      case (state_q)
        SCAN: begin
          // Sample only at the end of the dwell so the row drive and synchronizer have settled
          if (dwell_q == DWELL_LAST) begin
            dwell_q <= '0;
            if (is_onehot4(col_act)) begin
              cap_row_q <= idx_to_onehot(row_idx_q);
              cap_col_q <= col_act;
              db_q      <= '0;
              state_q   <= PRESS_DB;
            end else begin
              row_idx_q <= row_idx_q + 2'd1;
              row_n_q   <= ROW_IDLE ^ idx_to_onehot(row_idx_q + 2'd1);
            end
          end else begin
            dwell_q <= dwell_q + CNT_ONE;
          end
        end

        PRESS_DB: begin
          if (col_act == cap_col_q) begin
            if (db_q == DB_LAST) begin
              state_q     <= HELD;
              db_q        <= '0;
              key_code_q  <= dec_code;
              key_valid_q <= 1'b1;
              key_held_q  <= 1'b1;
            end else begin
              db_q <= db_q + CNT_ONE;
            end
          end else begin
            // Bounce: rescan the same row from the start of its dwell
            state_q <= SCAN;
            dwell_q <= '0;
            db_q    <= '0;
          end
        end

        HELD: begin
          if (!cap_bit_set) begin
            state_q <= RELEASE_DB;
            db_q    <= '0;
          end
        end

        RELEASE_DB: begin
          if (cap_bit_set) begin
            state_q <= HELD;
            db_q    <= '0;
          end else if (db_q == DB_LAST) begin
            state_q    <= SCAN;
            db_q       <= '0;
            dwell_q    <= '0;
            key_held_q <= 1'b0;
            row_idx_q  <= row_idx_q + 2'd1;
            row_n_q    <= ROW_IDLE ^ idx_to_onehot(row_idx_q + 2'd1);
          end else begin
            db_q <= db_q + CNT_ONE;
          end
        end

        default: state_q <= SCAN;
      endcase
    end
  end

  assign row_n     = row_n_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_keypad_scanner                                          |
// | Brief   : Self-checking bench for keypad_scanner with a behavioural  |
// |           keypad matrix and event-level reference model              |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;
  localparam int LAT      = 4 * SCAN_DIV + DEB + 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  // pressed[r*4+c] = key at row r, column c is physically down
  logic [15:0] pressed = 16'd0;

  // Printed legend of each key position, row-major
  logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hC,
                              4'h4, 4'h5, 4'h6, 4'hD,
                              4'h7, 4'h8, 4'h9, 4'hE,
                              4'hA, 4'h0, 4'hB, 4'hF};

  int total = 0;
  int bad   = 0;
  int pulses = 0;
  int viol   = 0;
  logic [3:0] last_pulse_code = 4'h0;
  logic       prev_valid = 1'b0;
  logic [3:0] prev_code  = 4'h0;

  keypad_scanner #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .col_n     (col_n),
    .row_n     (row_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Passive matrix: a column is pulled low when a pressed key sits on a driven row
  always_comb begin
    col_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
  end

  // Pulse counter and output invariants, sampled just after each rising edge
  always @(posedge clk) begin
    #1;
    if (reset_n) begin
      if (key_valid) begin
        pulses = pulses + 1;
        last_pulse_code = key_code;
      end else if (key_code != prev_code) begin
        viol = viol + 1;
      end
      if (key_valid && prev_valid) viol = viol + 1;
      if ($countones(~row_n) > 1) viol = viol + 1;
    end
    prev_valid = key_valid;
    prev_code  = key_code;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    int         key;
    logic [3:0] code;
  } vec_t;

  initial begin
    vec_t tbl [16];
    int base, cyc, trans, seq_bad;
    logic found;
    logic [3:0] prev_row;

    tbl = '{'{0, 4'h1}, '{1, 4'h2}, '{2, 4'h3}, '{3, 4'hC},
            '{4, 4'h4}, '{5, 4'h5}, '{6, 4'h6}, '{7, 4'hD},
            '{8, 4'h7}, '{9, 4'h8}, '{10, 4'h9}, '{11, 4'hE},
            '{12, 4'hA}, '{13, 4'h0}, '{14, 4'hB}, '{15, 4'hF}};

    // Reset state
    cycles(3);
    check("reset row_n", row_n, 4'b1110);
    check("reset key_code", key_code, 4'h0);
    check("reset key_valid", key_valid, 1'b0);
    check("reset key_held", key_held, 1'b0);
    reset_n = 1'b1;
    cycles(10);

    // 1: clean press of '5', latency bound and release timing
    base = pulses;
    pressed[5] = 1'b1;
    found = 1'b0;
    cyc = 0;
    for (int i = 1; i <= LAT + 20 && !found; i++) begin
      @(negedge clk);
      if (pulses > base) begin found = 1'b1; cyc = i; end
    end
    check("t1 pulse seen", found, 1'b1);
    check("t1 latency within bound", (cyc <= LAT), 1'b1);
    cycles(100 - cyc);
    check("t1 pulse count", pulses - base, 1);
    check("t1 key_code", key_code, 4'h5);
    check("t1 key_held during press", key_held, 1'b1);
    pressed[5] = 1'b0;
    cycles(5);
    check("t1 key_held early release", key_held, 1'b1);
    cycles(9);
    check("t1 key_held after release", key_held, 1'b0);
    cycles(10);

    // 2: every key in turn
    base = pulses;
    for (int i = 0; i < 16; i++) begin
      int b2;
      b2 = pulses;
      pressed[tbl[i].key] = 1'b1;
      cycles(60);
      check("t2 one pulse per key", pulses - b2, 1);
      check("t2 key code", key_code, tbl[i].code);
      pressed[tbl[i].key] = 1'b0;
      cycles(60);
    end
    check("t2 total pulses", pulses - base, 16);

    // 3: bouncing press and bouncing release of '9'
    base = pulses;
    for (int i = 0; i < 10; i++) begin
      pressed[10] = ~pressed[10];
      cycles(3);
    end
    pressed[10] = 1'b1;
    cycles(60);
    check("t3 one pulse after bounce", pulses - base, 1);
    check("t3 key code", key_code, 4'h9);
    for (int i = 0; i < 4; i++) begin
      pressed[10] = 1'b0;
      cycles(5);
      pressed[10] = 1'b1;
      cycles(2);
    end
    pressed[10] = 1'b0;
    cycles(30);
    check("t3 no pulse on release bounce", pulses - base, 1);
    check("t3 held cleared", key_held, 1'b0);

    // 4: first key wins, second accepted after first releases
    base = pulses;
    pressed[0] = 1'b1;
    cycles(60);
    check("t4 pulse for 1", pulses - base, 1);
    check("t4 code 1", key_code, 4'h1);
    pressed[15] = 1'b1;
    cycles(60);
    check("t4 no pulse for F while 1 held", pulses - base, 1);
    check("t4 code still 1", key_code, 4'h1);
    pressed[0] = 1'b0;
    cycles(80);
    check("t4 F accepted", pulses - base, 2);
    check("t4 code F", key_code, 4'hF);
    pressed[15] = 1'b0;
    cycles(30);

    // 5: two keys on one row never accepted; rows keep rotating
    base = pulses;
    pressed[1] = 1'b1;
    pressed[2] = 1'b1;
    prev_row = row_n;
    trans = 0;
    seq_bad = 0;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      if (row_n != prev_row) begin
        if (row_n != {prev_row[2:0], prev_row[3]}) seq_bad++;
        trans++;
        prev_row = row_n;
      end
    end
    check("t5 no pulse", pulses - base, 0);
    check("t5 row order", seq_bad, 0);
    check("t5 rows rotating", (trans >= 10), 1'b1);
    pressed[1] = 1'b0;
    pressed[2] = 1'b0;
    cycles(20);

    // 6: reset during HELD of 'E', then re-accept after reset
    base = pulses;
    pressed[11] = 1'b1;
    cycles(60);
    check("t6 pulse E", pulses - base, 1);
    check("t6 held", key_held, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("t6 reset row_n", row_n, 4'b1110);
    check("t6 reset key_code", key_code, 4'h0);
    check("t6 reset key_held", key_held, 1'b0);
    cycles(3);
    check("t6 no pulse in reset", key_valid, 1'b0);
    reset_n = 1'b1;
    base = pulses;
    cycles(60);
    check("t6 one pulse after reset", pulses - base, 1);
    check("t6 code E", key_code, 4'hE);
    pressed[11] = 1'b0;
    cycles(30);

    // Randomized episodes against the event-level model
    for (int e = 0; e < 12; e++) begin
      int k, len, gap, exp_pulses;
      logic long_press;
      k = $urandom_range(0, 15);
      long_press = 1'($urandom_range(0, 1));
      len = long_press ? $urandom_range(LAT + 10, LAT + 40) : $urandom_range(1, DEB - 2);
      gap = $urandom_range(20, 40);
      exp_pulses = long_press ? 1 : 0;
      base = pulses;
      pressed[k] = 1'b1;
      cycles(len);
      check("rnd held while pressed", key_held, long_press);
      pressed[k] = 1'b0;
      cycles(gap);
      check("rnd pulse count", pulses - base, exp_pulses);
      if (long_press) check("rnd key code", last_pulse_code, keymap[k]);
      check("rnd held after release", key_held, 1'b0);
    end

    check("output invariants", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
